numero_decoder: RTL and testbench
=================================

# numero_decoder

Receive-side counterpart of the digit encoder: accepts the 5-bit `v..z` code word the encoder produces (a 5-bit Johnson-ring code for decimal digits 0–9) and recovers the 4-bit digit `a..d`. It sits at the consumer end of the encoded link. It buffers one decoded digit behind a valid/ack handshake, flags illegal code words, and keeps a saturating count of them.

## Interface
Parameters:
- `ERR_W`, default 8: width of the illegal-code counter.

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `v, w, x, y, z`  input  1 each  code word; `v` is the MSB, `z` the LSB.
- `in_valid`  input  1  code word is present this cycle.
- `in_ready`  output  1  block can accept a code word this cycle.
- `out_a, out_b, out_c, out_d`  output  1 each  decoded digit; `out_a` is the MSB.
- `out_valid`  output  1  buffered result is available.
- `out_ack`  input  1  consumer takes the buffered result this cycle.
- `out_error`  output  1  the buffered result came from an illegal code word.
- `err_count`  output  `ERR_W`  number of illegal code words accepted since reset; saturates.

## Operation
- **Code map** (`vwxyz` -> digit):
  - 11100->0, 11110->1, 11111->2, 01111->3, 00111->4
  - 00011->5, 00001->6, 00000->7, 10000->8, 11000->9
- **Illegal words:** the other 22 code words are illegal. They decode to digit 4'b1111 with `out_error`=1.
- **Buffer states:** one-entry output buffer with two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept together with `out_ack` (the buffer is overwritten with the new result).
  - FULL -> EMPTY on `out_ack` without accept.
  - `out_ack` while EMPTY is ignored.
- **`in_ready`** = `~reset & (EMPTY | out_ack)`. It is combinational.
- **Accept** = `in_valid & in_ready`. On accept, at the next clock edge:
  - the digit and `out_error` are loaded;
  - `out_valid` = 1;
  - if the word is illegal, `err_count` increments.
- **Holding:** while FULL and not acked, `out_a..d`, `out_error` and `out_valid` hold steady. Input words presented meanwhile are not accepted and not counted.
- **`err_count`:** increments by 1 per accepted illegal word. It stops at 2^ERR_W−1 and does not wrap. It is cleared only by `reset`.
- `v..z` are sampled only on accept; their value at other times is don't-care.

## Timing
- **Reset values** (synchronous, applied at the edge where `reset`=1):
  - `out_a..d`=0, `out_valid`=0, `out_error`=0, `err_count`=0;
  - state=EMPTY.
  - `in_ready`=0 during every cycle `reset` is high.
- **Reset mid-operation:** a buffered result is discarded, `out_valid` falls at that edge, and `err_count` clears.
- **Latency:** code word accepted at edge N -> `out_valid` and the digit are visible after edge N, i.e. 1 cycle.
- **Throughput:** 1 word/cycle is sustained when the consumer acks in every cycle that `out_valid`=1.
- **Simultaneous accept and ack:** the old result is retired and the new one loaded at the same edge; `out_valid` stays 1 with no bubble.
- **Ack timing:** `out_ack` is only meaningful while `out_valid`=1. A result is consumed exactly at the edge where `out_valid & out_ack`.
- **Counter saturation:** an illegal word accepted while `err_count` = max still loads into the buffer with `out_error`=1. The count is unchanged.
- There are no combinational paths from `v..z` to any output. The only combinational path is `out_ack` -> `in_ready`.

## Test plan
- **Reset:** hold `reset` for 2 cycles with `in_valid`=1 and code 11100 -> all outputs 0, `in_ready`=0, nothing accepted. After release, `in_ready`=1.
- **Full-map sweep:** apply codes 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000, 10000, 11000 back-to-back with `out_ack`=1 -> digits 0..9, one per cycle after 1 cycle of latency, `out_error`=0 throughout, `err_count`=0.
- **Illegal words:** apply 01010, 10101, 11101 -> each output is 4'b1111 with `out_error`=1; `err_count` ends at 3.
- **Backpressure:**
  - Accept 00111 with `out_ack`=0 -> `out_valid`=1, digit 4, `in_ready`=0.
  - Present 00000 for 3 cycles -> the output holds 4 and nothing is counted.
  - Assert `out_ack` -> 00000 is accepted in that cycle, and digit 7 appears on the next cycle.
- **Saturation:** with `ERR_W`=2, apply 5 illegal words -> `err_count` reads 1, 2, 3, 3, 3.
- **Reset while FULL:** with digit 9 buffered and `out_ack`=0, pulse `reset` for 1 cycle -> `out_valid`=0 and the digit is 0 on the next cycle. The next accept of 11110 yields digit 1.

Source files
------------

// File: rtl/numero_decoder_if.sv
// Handshake and data bundle between a Johnson-code producer and the digit decoder.
// The master side drives the code word, in_valid and out_ack; the slave side
// (the decoder) returns in_ready, the decoded digit, status and the error count.
interface numero_decoder_if #(
    parameter int ERR_W = 8
);
    logic             v;
    logic             w;
    logic             x;
    logic             y;
    logic             z;
    logic             in_valid;
    logic             in_ready;
    logic             out_a;
    logic             out_b;
    logic             out_c;
    logic             out_d;
    logic             out_valid;
    logic             out_ack;
    logic             out_error;
    logic [ERR_W-1:0] err_count;

    modport master (
        output v, w, x, y, z, in_valid, out_ack,
        input  in_ready, out_a, out_b, out_c, out_d, out_valid, out_error, err_count
    );

    modport slave (
        input  v, w, x, y, z, in_valid, out_ack,
        output in_ready, out_a, out_b, out_c, out_d, out_valid, out_error, err_count
    );
endinterface

// File: rtl/numero_decoder.sv
// Johnson-ring code word to decimal digit decoder with a one-entry output buffer.
// Illegal code words decode to 4'b1111 with out_error set and bump a saturating
// error counter. The only combinational path to an output is out_ack -> in_ready.
module numero_decoder #(
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    numero_decoder_if.slave   bus
);

    localparam logic [0:0]       EMPTY   = 1'b0;
    localparam logic [0:0]       FULL    = 1'b1;
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [0:0]       state;
    logic [3:0]       digit_q;
    logic             error_q;
    logic [ERR_W-1:0] err_q;

    logic [4:0]       code;
    logic [3:0]       dec_digit;
    logic             dec_illegal;
    logic             accept;

    assign code = {bus.v, bus.w, bus.x, bus.y, bus.z};

    // Map the ten legal ring positions to digits; everything else is illegal.
    always_comb begin
        dec_digit   = 4'b1111;
        dec_illegal = 1'b1;
        case (code)
            5'b11100: begin dec_digit = 4'd0; dec_illegal = 1'b0; end
            5'b11110: begin dec_digit = 4'd1; dec_illegal = 1'b0; end
            5'b11111: begin dec_digit = 4'd2; dec_illegal = 1'b0; end
            5'b01111: begin dec_digit = 4'd3; dec_illegal = 1'b0; end
            5'b00111: begin dec_digit = 4'd4; dec_illegal = 1'b0; end
            5'b00011: begin dec_digit = 4'd5; dec_illegal = 1'b0; end
            5'b00001: begin dec_digit = 4'd6; dec_illegal = 1'b0; end
            5'b00000: begin dec_digit = 4'd7; dec_illegal = 1'b0; end
            5'b10000: begin dec_digit = 4'd8; dec_illegal = 1'b0; end
            5'b11000: begin dec_digit = 4'd9; dec_illegal = 1'b0; end
            default:  begin dec_digit = 4'b1111; dec_illegal = 1'b1; end
        endcase
    end

    // Ready whenever the buffer is free or is being drained this very cycle.
    assign bus.in_ready = ~reset & ((state == EMPTY) | bus.out_ack);
    assign accept       = bus.in_valid & bus.in_ready;

    // Buffer occupancy: fill on accept, drain on ack without a replacement.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else if (accept) begin
            state <= FULL;
        end else if (bus.out_ack) begin
            state <= EMPTY;
        end
    end

    // Capture the decoded digit and its error flag only on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= 4'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            digit_q <= dec_digit;
            error_q <= dec_illegal;
        end
    end

    // Count accepted illegal words, sticking at the all-ones value.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (accept && dec_illegal && (err_q != ERR_MAX)) begin
            err_q <= err_q + ERR_ONE;
        end
    end

    assign bus.out_a     = digit_q[3];
    assign bus.out_b     = digit_q[2];
    assign bus.out_c     = digit_q[1];
    assign bus.out_d     = digit_q[0];
    assign bus.out_error = error_q;
    assign bus.out_valid = (state == FULL);
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_numero_decoder.sv
// Scoreboard bench for numero_decoder: two instances (8-bit and 2-bit error
// counters) share one stimulus stream; a negedge monitor checks both.
module tb_numero_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] code;
    logic       in_valid;
    logic       out_ack;

    always #5 clk = ~clk;

    numero_decoder_if #(.ERR_W(8)) bus8 ();
    numero_decoder_if #(.ERR_W(2)) bus2 ();

    numero_decoder #(.ERR_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    numero_decoder #(.ERR_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    assign {bus8.v, bus8.w, bus8.x, bus8.y, bus8.z} = code;
    assign {bus2.v, bus2.w, bus2.x, bus2.y, bus2.z} = code;
    assign bus8.in_valid = in_valid;
    assign bus2.in_valid = in_valid;
    assign bus8.out_ack  = out_ack;
    assign bus2.out_ack  = out_ack;

    typedef struct packed {
        logic [3:0] digit;
        logic       error;
    } exp_t;

    localparam logic [4:0] CODES [10] = '{
        5'b11100, 5'b11110, 5'b11111, 5'b01111, 5'b00111,
        5'b00011, 5'b00001, 5'b00000, 5'b10000, 5'b11000
    };

    exp_t        sb[$];
    int unsigned cnt8;
    int unsigned cnt2;
    bit          zero_flag;
    bit          started;
    int          checks;
    int          fails;

    // Reference decode: position of the word in the ring table is the digit.
    function automatic exp_t model_decode(input logic [4:0] c);
        exp_t e;
        e.digit = 4'hF;
        e.error = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (CODES[i] == c) begin
                e.digit = 4'(i);
                e.error = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then update the model at the clock edge.
    task automatic applyStimulus(input logic [4:0] c, input bit vld, input bit ack, input bit rst);
        exp_t e;
        code     = c;
        in_valid = vld;
        out_ack  = ack;
        reset    = rst;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            cnt8      = 0;
            cnt2      = 0;
            zero_flag = 1'b1;
            started   = 1'b1;
        end else if (vld && (sb.size() == 0 || ack)) begin
            e = model_decode(c);
            sb.push_back(e);
            zero_flag = 1'b0;
            if (e.error) begin
                if (cnt8 < 255) cnt8++;
                if (cnt2 < 3)   cnt2++;
            end
        end
        #1;
    endtask

    // Monitor: compare presented outputs against the scoreboard, retire on ack.
    always @(negedge clk) begin
        bit exp_ready;
        if (started) begin
            exp_ready = !reset && (sb.size() == 0 || out_ack);
            checkOutput("in_ready8", int'(bus8.in_ready), int'(exp_ready));
            checkOutput("in_ready2", int'(bus2.in_ready), int'(exp_ready));
            checkOutput("out_valid8", int'(bus8.out_valid), int'(sb.size() != 0));
            checkOutput("out_valid2", int'(bus2.out_valid), int'(sb.size() != 0));
            if (sb.size() != 0) begin
                checkOutput("digit8", int'({bus8.out_a, bus8.out_b, bus8.out_c, bus8.out_d}), int'(sb[0].digit));
                checkOutput("error8", int'(bus8.out_error), int'(sb[0].error));
                checkOutput("digit2", int'({bus2.out_a, bus2.out_b, bus2.out_c, bus2.out_d}), int'(sb[0].digit));
                checkOutput("error2", int'(bus2.out_error), int'(sb[0].error));
                if (out_ack) void'(sb.pop_front());
            end else if (zero_flag) begin
                checkOutput("reset_digit8", int'({bus8.out_a, bus8.out_b, bus8.out_c, bus8.out_d}), 0);
                checkOutput("reset_error8", int'(bus8.out_error), 0);
            end
            checkOutput("err_count8", int'(bus8.err_count), int'(cnt8));
            checkOutput("err_count2", int'(bus2.err_count), int'(cnt2));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        checks    = 0;
        fails     = 0;
        started   = 1'b0;
        zero_flag = 1'b1;
        cnt8      = 0;
        cnt2      = 0;

        applyStimulus(5'b11100, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b11100, 1'b1, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) applyStimulus(CODES[i], 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

        applyStimulus(5'b01010, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b10101, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b11101, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00010, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b01000, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

        applyStimulus(5'b00111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'b00000, 1'b1, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

        applyStimulus(5'b11000, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'b11000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);
        applyStimulus(5'b11110, 1'b1, 1'b0, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            applyStimulus(5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 8),
                          ($urandom_range(0, 9) < 7), 1'b0);
        end
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(5'($urandom_range(0, 31)), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 9) < 5), ($urandom_range(0, 99) == 0));
        end
        applyStimulus(5'b00000, 1'b0, 1'b1, 1'b0);
        applyStimulus(5'b00000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
